// File: rtl/nes_pad_pkg.sv
// rtl/nes_pad_pkg.sv - shared types and constants for the NES pad reader
//
// Contents:
//   pad_state_e      frame sequencer states
//   PAD_BITS         number of serial bits per pad frame
//   BTN_A..BTN_RIGHT bit positions of each button in controller_data

package nes_pad_pkg;

  localparam int PAD_BITS = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    SETTLE = 3'd2,
    CLK_HI = 3'd3,
    CLK_LO = 3'd4,
    DONE   = 3'd5
  } pad_state_e;

endpackage

// File: rtl/pad_sync.sv
// rtl/pad_sync.sv - two-flop synchronizer for the asynchronous pad data line
//
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous active-low reset
//   d_in   in  asynchronous input
//   d_out  out synchronized copy of d_in (two-cycle latency)
//
// Resets to 1 because the idle pad line reads as "not pressed".

module pad_sync (
  input  logic clk,
  input  logic reset,
  input  logic d_in,
  output logic d_out
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d_in};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign d_out = sync_q[1];

endmodule

// File: rtl/nes_pad_reader.sv
// rtl/nes_pad_reader.sv - NES-style serial pad poller producing controller_data
//
// Parameters:
//   POLL_DIV     idle cycles between frames (min 2)
//   HALF_PERIOD  cycles per pad-clock half period H (min 4)
// Ports:
//   clk              in  system clock
//   reset            in  asynchronous active-low reset
//   poll_en          in  permits new frames to start
//   pad_data         in  serial pad data, asynchronous, active-low
//   int_ack          in  clears change_int
//   pad_latch        out parallel-load strobe to the pad
//   pad_clk          out shift clock to the pad
//   controller_data  out button byte, 1 = pressed
//   data_valid       out one-cycle pulse when controller_data updates
//   change_int       out sticky interrupt request, set when the byte changed

module nes_pad_reader
  import nes_pad_pkg::*;
#(
  parameter int POLL_DIV    = 833333,
  parameter int HALF_PERIOD = 300
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                poll_en,
  input  logic                pad_data,
  input  logic                int_ack,
  output logic                pad_latch,
  output logic                pad_clk,
  output logic [PAD_BITS-1:0] controller_data,
  output logic                data_valid,
  output logic                change_int
);

  localparam int PC_W = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 1;
  localparam int PH_W = $clog2(2 * HALF_PERIOD);

  localparam logic [PC_W-1:0] PC_MAX       = PC_W'(POLL_DIV - 1);
  localparam logic [PH_W-1:0] PH_LATCH_END = PH_W'(2 * HALF_PERIOD - 1);
  localparam logic [PH_W-1:0] PH_HALF_END  = PH_W'(HALF_PERIOD - 1);
  localparam logic [2:0]      BIT_LAST_M1  = 3'(PAD_BITS - 2);

  logic pad_s;

  pad_sync u_pad_sync (
    .clk   (clk),
    .reset (reset),
    .d_in  (pad_data),
    .d_out (pad_s)
  );

  pad_state_e          state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [PAD_BITS-1:0] shreg_q, shreg_d;
  logic [PAD_BITS-1:0] controller_data_q, controller_data_d;
  logic                pad_latch_q, pad_latch_d;
  logic                pad_clk_q, pad_clk_d;
  logic                data_valid_q, data_valid_d;
  logic                change_int_q, change_int_d;

  // Bits arrive A first; shifting right leaves A in bit 0 after eight shifts.
  // The pad drives active-low, so each sample is inverted on the way in.
  logic [PAD_BITS-1:0] shreg_shifted;
  assign shreg_shifted = {~pad_s, shreg_q[PAD_BITS-1:1]};

  always_comb begin
    state_d           = state_q;
    pc_d              = pc_q;
    phase_d           = phase_q;
    bit_idx_d         = bit_idx_q;
    shreg_d           = shreg_q;
    controller_data_d = controller_data_q;
    data_valid_d      = 1'b0;
    // A set in DONE below overrides this clear, so set wins over int_ack.
    change_int_d      = change_int_q & ~int_ack;

    unique case (state_q)
      IDLE: begin
        phase_d   = '0;
        bit_idx_d = '0;
        // pc saturates, so a frame starts the cycle poll_en rises after a hold.
        if (pc_q == PC_MAX) begin
          if (poll_en) begin
            state_d = LATCH;
            pc_d    = '0;
          end
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end

      LATCH: begin
        if (phase_q == PH_LATCH_END) begin
          phase_d = '0;
          state_d = SETTLE;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      SETTLE: begin
        if (phase_q == PH_HALF_END) begin
          phase_d = '0;
          shreg_d = shreg_shifted;
          state_d = CLK_HI;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      CLK_HI: begin
        if (phase_q == PH_HALF_END) begin
          phase_d = '0;
          state_d = CLK_LO;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      CLK_LO: begin
        if (phase_q == PH_HALF_END) begin
          phase_d   = '0;
          shreg_d   = shreg_shifted;
          bit_idx_d = bit_idx_q + 3'd1;
          // bit_idx_q is the index of the bit already taken; this shift takes the next.
          if (bit_idx_q == BIT_LAST_M1) begin
            state_d = DONE;
          end else begin
            state_d = CLK_HI;
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      DONE: begin
        controller_data_d = shreg_q;
        data_valid_d      = 1'b1;
        if (shreg_q != controller_data_q) begin
          change_int_d = 1'b1;
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Pad strobes follow the next state so they line up with the state register.
    pad_latch_d = (state_d == LATCH);
    pad_clk_d   = (state_d == CLK_HI);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= IDLE;
      pc_q              <= '0;
      phase_q           <= '0;
      bit_idx_q         <= '0;
      shreg_q           <= '0;
      controller_data_q <= '0;
      pad_latch_q       <= 1'b0;
      pad_clk_q         <= 1'b0;
      data_valid_q      <= 1'b0;
      change_int_q      <= 1'b0;
    end else begin
      state_q           <= state_d;
      pc_q              <= pc_d;
      phase_q           <= phase_d;
      bit_idx_q         <= bit_idx_d;
      shreg_q           <= shreg_d;
      controller_data_q <= controller_data_d;
      pad_latch_q       <= pad_latch_d;
      pad_clk_q         <= pad_clk_d;
      data_valid_q      <= data_valid_d;
      change_int_q      <= change_int_d;
    end
  end

  assign pad_latch       = pad_latch_q;
  assign pad_clk         = pad_clk_q;
  assign controller_data = controller_data_q;
  assign data_valid      = data_valid_q;
  assign change_int      = change_int_q;

endmodule

// File: tb/tb_nes_pad_reader.sv
// tb/tb_nes_pad_reader.sv - scoreboard testbench for nes_pad_reader

module tb_nes_pad_reader;
  import nes_pad_pkg::*;

  localparam int POLL_DIV = 16;
  localparam int H        = 4;
  localparam int FRAME    = 17 * H + 1;
  localparam int PERIOD   = POLL_DIV + FRAME;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       poll_en = 1'b0;
  logic       pad_data = 1'b1;
  logic       int_ack = 1'b0;
  logic       pad_latch;
  logic       pad_clk;
  logic [7:0] controller_data;
  logic       data_valid;
  logic       change_int;

  always #5 clk = ~clk;

  nes_pad_reader #(
    .POLL_DIV    (POLL_DIV),
    .HALF_PERIOD (H)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .poll_en         (poll_en),
    .pad_data        (pad_data),
    .int_ack         (int_ack),
    .pad_latch       (pad_latch),
    .pad_clk         (pad_clk),
    .controller_data (controller_data),
    .data_valid      (data_valid),
    .change_int      (change_int)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       chg;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Pad model: a 4021 that captures the buttons when the latch falls and
  // shifts on each pad_clk rise; each capture is one expected frame.
  logic [7:0] buttons = 8'h00;
  logic [7:0] pad_sr = 8'hFF;
  logic [7:0] model_prev = 8'h00;

  always @(negedge pad_latch) begin
    if (reset) begin
      exp_t e;
      pad_sr   = ~buttons;
      pad_data = pad_sr[0];
      e.data   = buttons;
      e.chg    = (buttons != model_prev);
      exp_q.push_back(e);
      model_prev = buttons;
    end
  end

  always @(posedge pad_clk) begin
    pad_sr   = {1'b1, pad_sr[7:1]};
    pad_data = pad_sr[0];
  end

  // Monitor
  int   latch_cyc = -1;
  int   last_latch = -1;
  int   rel_cyc = 0;
  int   n_rises = 0;
  bit   first_after_rst = 1'b0;
  bit   period_chk = 1'b1;
  logic latch_prev = 1'b0;
  logic exp_int = 1'b0;
  logic [7:0] mon_data = 8'h00;

  always @(posedge clk) begin
    logic ack_e;
    exp_t e;
    ack_e = int_ack;
    #1;
    if (!reset) begin
      exp_int    = 1'b0;
      latch_prev = 1'b0;
      mon_data   = 8'h00;
      latch_cyc  = -1;
      last_latch = -1;
    end else begin
      if (pad_latch && !latch_prev) begin
        n_rises++;
        if (first_after_rst) begin
          chk("first_latch_delay", 32'(cyc - rel_cyc), 32'(POLL_DIV));
          first_after_rst = 1'b0;
        end else if (period_chk && last_latch >= 0) begin
          chk("frame_period", 32'(cyc - last_latch), 32'(PERIOD));
        end
        last_latch = cyc;
        latch_cyc  = cyc;
      end
      latch_prev = pad_latch;
      if (data_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid actual=1 required=0 at cycle %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("controller_data", 32'(controller_data), 32'(e.data));
          mon_data = e.data;
          if (e.chg) exp_int = 1'b1;
          else if (ack_e) exp_int = 1'b0;
          if (latch_cyc >= 0) chk("latch_to_valid", 32'(cyc - latch_cyc), 32'(FRAME));
        end
      end else begin
        if (ack_e) exp_int = 1'b0;
        chk("data_hold", 32'(controller_data), 32'(mon_data));
      end
      chk("change_int", 32'(change_int), 32'(exp_int));
    end
  end

  task automatic wait_dv(input string tag);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 300) begin
      @(posedge clk);
      #2;
      if (data_valid) seen = 1'b1;
      n++;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_valid_timeout actual=0 required=1", tag);
    end
  endtask

  task automatic wait_latch(input string tag);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 300) begin
      @(posedge clk);
      #2;
      if (pad_latch) seen = 1'b1;
      n++;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_latch_timeout actual=0 required=1", tag);
    end
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
  endtask

  initial begin
    #(200000);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int r;
    int k;
    #2;
    reset   = 1'b0;
    poll_en = 1'b1;
    buttons = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_pad_latch", 32'(pad_latch), 0);
    chk("rst_pad_clk", 32'(pad_clk), 0);
    chk("rst_controller_data", 32'(controller_data), 0);
    chk("rst_data_valid", 32'(data_valid), 0);
    chk("rst_change_int", 32'(change_int), 0);
    reset           = 1'b1;
    rel_cyc         = cyc;
    first_after_rst = 1'b1;

    // No buttons pressed
    wait_dv("idle_pad");
    @(negedge clk);
    chk("no_press_int", 32'(change_int), 0);

    // A + Right
    buttons = 8'((1 << BTN_A) | (1 << BTN_RIGHT));
    wait_dv("a_right");
    @(negedge clk);
    chk("a_right_int", 32'(change_int), 1);
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
    chk("a_right_acked", 32'(change_int), 0);

    // Same byte again, then Start only
    wait_dv("repeat");
    @(negedge clk);
    chk("repeat_int", 32'(change_int), 0);
    buttons = 8'(1 << BTN_START);
    wait_dv("start");
    @(negedge clk);
    chk("start_int", 32'(change_int), 1);
    ack_pulse();

    // int_ack in the DONE cycle of a changing frame: set wins
    buttons = 8'h42;
    wait_latch("done_ack");
    repeat (68) @(posedge clk);
    @(negedge clk);
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
    chk("set_wins_int", 32'(change_int), 1);
    chk("set_wins_data", 32'(controller_data), 32'h42);
    ack_pulse();
    wait_dv("after_done_ack");

    // Random frames with random acknowledges
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      buttons = 8'($urandom);
      k = $urandom_range(0, 60);
      repeat (k) @(negedge clk);
      int_ack = 1'($urandom);
      @(negedge clk);
      int_ack = 1'b0;
      wait_dv("random");
    end

    // poll_en dropped during CLK_HI of bit 3
    @(negedge clk);
    buttons = 8'($urandom);
    wait_latch("poll_drop");
    repeat (29) @(posedge clk);
    @(negedge clk);
    poll_en    = 1'b0;
    period_chk = 1'b0;
    wait_dv("poll_drop");
    r = n_rises;
    repeat (40) @(negedge clk);
    chk("no_latch_while_disabled", 32'(n_rises), 32'(r));
    chk("latch_low_while_disabled", 32'(pad_latch), 0);
    poll_en = 1'b1;
    @(posedge clk);
    #2;
    chk("latch_after_enable", 32'(pad_latch), 1);
    wait_dv("poll_resume");
    period_chk = 1'b1;

    // Reset during CLK_LO of bit 5 with prior byte 0x81
    @(negedge clk);
    buttons = 8'h81;
    wait_dv("pre_reset");
    @(negedge clk);
    buttons = 8'($urandom);
    wait_latch("mid_reset");
    repeat (49) @(posedge clk);
    @(negedge clk);
    reset      = 1'b0;
    period_chk = 1'b0;
    exp_q.delete();
    model_prev = 8'h00;
    #1;
    chk("mid_rst_pad_latch", 32'(pad_latch), 0);
    chk("mid_rst_pad_clk", 32'(pad_clk), 0);
    chk("mid_rst_controller_data", 32'(controller_data), 0);
    chk("mid_rst_data_valid", 32'(data_valid), 0);
    chk("mid_rst_change_int", 32'(change_int), 0);
    repeat (3) @(negedge clk);
    reset           = 1'b1;
    rel_cyc         = cyc;
    first_after_rst = 1'b1;
    buttons         = 8'h3C;
    wait_dv("post_reset");
    period_chk = 1'b1;
    @(negedge clk);
    chk("post_reset_data", 32'(controller_data), 32'h3C);
    buttons = 8'($urandom);
    wait_dv("post_reset_2");
    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
